// File: rtl/led_pattern_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer.
// Holds the register map, control/status bit positions and FSM states.
package led_seq_pkg;

    localparam int DEF_NUM_LEDS = 26;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_DWELL_W  = 32;

    localparam logic [4:0] REG_CTRL   = 5'h00;
    localparam logic [4:0] REG_STATUS = 5'h01;
    localparam logic [4:0] REG_LENGTH = 5'h02;
    localparam logic [4:0] REG_DWELL  = 5'h03;

    // Table entries live at 0x10-0x1F.
    localparam int TABLE_BIT = 4;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_LOOP   = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_IDX  = 4;
    localparam int ST_DONE = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_DWELL = 2'd3
    } seq_state_e;

    function automatic logic is_table(input logic [4:0] addr);
        return addr[TABLE_BIT];
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Bus bundle for the LED pattern sequencer.
// CSR slave side (s_*), fade-peripheral master side (m_*) and irq.
interface led_pattern_sequencer_if;

    logic [4:0]  s_address;
    logic        s_write;
    logic [31:0] s_writedata;
    logic        s_read;
    logic [31:0] s_readdata;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic        irq;

    // Sequencer view.
    modport slave (
        input  s_address,
        input  s_write,
        input  s_writedata,
        input  s_read,
        input  m_waitrequest,
        output s_readdata,
        output m_write,
        output m_writedata,
        output irq
    );

    // CPU / fade-peripheral view.
    modport master (
        output s_address,
        output s_write,
        output s_writedata,
        output s_read,
        output m_waitrequest,
        input  s_readdata,
        input  m_write,
        input  m_writedata,
        input  irq
    );

endinterface

// File: rtl/led_pattern_sequencer_pattern_ram.sv
// Pattern table: DEPTH x NUM_LEDS, one CSR write port.
// Ports: we/waddr/wdata write; fetch_* sync read for playback; csr_* sync read for readback.
module led_seq_pattern_ram #(
    parameter int NUM_LEDS = 26,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                clk_clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [NUM_LEDS-1:0] wdata,
    input  logic                fetch_re,
    input  logic [AW-1:0]       fetch_addr,
    output logic [NUM_LEDS-1:0] fetch_q,
    input  logic                csr_re,
    input  logic [AW-1:0]       csr_addr,
    output logic [NUM_LEDS-1:0] csr_q
);

    logic [NUM_LEDS-1:0] mem [DEPTH];

    // Table contents are undefined after reset, so no reset here.
    always_ff @(posedge clk_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (fetch_re) begin
            fetch_q <= mem[fetch_addr];
        end
        if (csr_re) begin
            csr_q <= mem[csr_addr];
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Plays a table of LED masks to the fade peripheral, one Avalon write per step.
// Ports: clk_clk, rst_reset_n (async, active-low), bus (CSR slave + fade master + irq).
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int DWELL_W  = DEF_DWELL_W
) (
    input  logic                  clk_clk,
    input  logic                  rst_reset_n,
    led_pattern_sequencer_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = IDX_W + 1;

    seq_state_e state;
    seq_state_e state_nxt;

    logic               run;
    logic               loop;
    logic               irq_en;
    logic               done;
    logic [LEN_W-1:0]   len;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] cnt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [31:0]        m_data;
    logic [31:0]        rdata;
    logic [31:0]        rd_val;
    logic               tbl_rd;

    logic sel_ctrl;
    logic sel_status;
    logic sel_len;
    logic sel_dwell;
    logic sel_tbl;
    logic ctrl_wr;
    logic status_wr;
    logic len_wr;
    logic dwell_wr;
    logic tbl_wr;

    logic               busy;
    logic               run_eff;
    logic               start;
    logic               accept;
    logic               dwell_last;
    logic               more;
    logic               seq_end;
    logic [LEN_W-1:0]   idx_inc;
    logic [LEN_W-1:0]   len_clamped;
    logic [DWELL_W-1:0] dwell_load;

    logic [NUM_LEDS-1:0] fetch_q;
    logic [NUM_LEDS-1:0] csr_q;

    // CSR decode
    assign sel_ctrl   = (bus.s_address == REG_CTRL);
    assign sel_status = (bus.s_address == REG_STATUS);
    assign sel_len    = (bus.s_address == REG_LENGTH);
    assign sel_dwell  = (bus.s_address == REG_DWELL);
    assign sel_tbl    = is_table(bus.s_address);

    assign ctrl_wr   = bus.s_write & sel_ctrl;
    assign status_wr = bus.s_write & sel_status;
    assign len_wr    = bus.s_write & sel_len;
    assign dwell_wr  = bus.s_write & sel_dwell;
    assign tbl_wr    = bus.s_write & sel_tbl;

    // A CTRL write in this cycle steers the FSM right away, so a stop
    // lands in IDLE on the very next cycle and a start hits FETCH next.
    assign run_eff = ctrl_wr ? bus.s_writedata[CTRL_RUN] : run;
    assign start   = ctrl_wr & bus.s_writedata[CTRL_RUN] & (len != '0);

    assign accept     = (state == S_WRITE) & ~bus.m_waitrequest;
    assign dwell_last = (cnt <= DWELL_W'(1));
    assign idx_inc    = {1'b0, idx} + LEN_W'(1);
    // A LENGTH shrunk below the current position ends the table here.
    assign more       = (idx_inc < len);
    assign dwell_load = (dwell == '0) ? DWELL_W'(1) : dwell;

    always_comb begin
        len_clamped = bus.s_writedata[LEN_W-1:0];
        if (bus.s_writedata > 32'(DEPTH)) begin
            len_clamped = LEN_W'(DEPTH);
        end
    end

    // FSM: state register
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        seq_end   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    idx_nxt   = '0;
                end
            end
            S_FETCH: begin
                state_nxt = run_eff ? S_WRITE : S_IDLE;
            end
            S_WRITE: begin
                // Never abandon a transfer the slave is stalling.
                if (!bus.m_waitrequest) begin
                    state_nxt = run_eff ? S_DWELL : S_IDLE;
                end
            end
            S_DWELL: begin
                if (!run_eff) begin
                    state_nxt = S_IDLE;
                end else if (dwell_last) begin
                    if (more) begin
                        state_nxt = S_FETCH;
                        idx_nxt   = idx_inc[IDX_W-1:0];
                    end else if (loop) begin
                        state_nxt = S_FETCH;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = S_IDLE;
                        seq_end   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy            = (state != S_IDLE);
        bus.m_write     = (state == S_WRITE);
        bus.m_writedata = m_data;
        bus.irq         = done & irq_en;
        bus.s_readdata  = tbl_rd ? 32'(csr_q) : rdata;
    end

    // CTRL and DONE
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            run    <= 1'b0;
            loop   <= 1'b0;
            irq_en <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= bus.s_writedata[CTRL_IRQ_EN];
                loop   <= bus.s_writedata[CTRL_LOOP];
                // From IDLE a run with an empty table never starts.
                run    <= bus.s_writedata[CTRL_RUN] & (busy | (len != '0));
            end
            if (seq_end) begin
                run <= 1'b0;
            end
            if (seq_end) begin
                done <= 1'b1;
            end else if (status_wr && bus.s_writedata[ST_DONE]) begin
                done <= 1'b0;
            end
        end
    end

    // LENGTH and DWELL
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            len   <= '0;
            dwell <= '0;
        end else begin
            if (len_wr) begin
                len <= len_clamped;
            end
            if (dwell_wr) begin
                dwell <= bus.s_writedata[DWELL_W-1:0];
            end
        end
    end

    // Dwell counter, index and master output register
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            cnt    <= '0;
            idx    <= '0;
            m_data <= '0;
        end else begin
            idx <= idx_nxt;
            if (accept) begin
                cnt <= dwell_load;
            end else if (state == S_DWELL) begin
                cnt <= cnt - DWELL_W'(1);
            end
            if (state == S_FETCH) begin
                m_data <= 32'(fetch_q);
            end
        end
    end

    // CSR read mux
    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_ctrl: begin
                rd_val[CTRL_RUN]    = run;
                rd_val[CTRL_LOOP]   = loop;
                rd_val[CTRL_IRQ_EN] = irq_en;
            end
            sel_status: begin
                rd_val[ST_DONE]          = done;
                rd_val[ST_IDX +: IDX_W]  = idx;
                rd_val[ST_BUSY]          = busy;
            end
            sel_len: begin
                rd_val = 32'(len);
            end
            sel_dwell: begin
                rd_val = 32'(dwell);
            end
            default: begin
                rd_val = '0;
            end
        endcase
    end

    // Fixed one-cycle read latency; table reads come from the RAM port.
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            rdata  <= '0;
            tbl_rd <= 1'b0;
        end else if (bus.s_read) begin
            rdata  <= rd_val;
            tbl_rd <= sel_tbl;
        end
    end

    // The fetch read is issued on the edge entering FETCH so the mask
    // is ready to register on the FETCH -> WRITE edge.
    led_seq_pattern_ram #(
        .NUM_LEDS (NUM_LEDS),
        .DEPTH    (DEPTH),
        .AW       (IDX_W)
    ) u_ram (
        .clk_clk    (clk_clk),
        .we         (tbl_wr),
        .waddr      (bus.s_address[IDX_W-1:0]),
        .wdata      (bus.s_writedata[NUM_LEDS-1:0]),
        .fetch_re   (state_nxt == S_FETCH),
        .fetch_addr (idx_nxt),
        .fetch_q    (fetch_q),
        .csr_re     (bus.s_read & sel_tbl),
        .csr_addr   (bus.s_address[IDX_W-1:0]),
        .csr_q      (csr_q)
    );

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer.
// Stimulus pushes expected writes/reads; a negedge monitor pops and compares.
module tb_led_pattern_sequencer;
    import led_seq_pkg::*;

    logic clk_clk;
    logic rst_reset_n;

    led_pattern_sequencer_if bus ();

    led_pattern_sequencer dut (
        .clk_clk     (clk_clk),
        .rst_reset_n (rst_reset_n),
        .bus         (bus)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic [31:0] data;
        int          gap;
        bit          from_ctrl;
        int          hold;
    } exp_t;

    exp_t        wq [$];
    logic [31:0] rq [$];
    string       rn [$];

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int n_acc = 0;
    int last_acc = 0;
    int last_ctrl = 0;
    int hold_cnt = 0;
    bit rd_pend = 0;
    exp_t e;

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: CSR read data one cycle after s_read, and every accepted
    // fade write against the head of the write queue.
    always @(negedge clk_clk) begin
        ncyc++;
        if (rd_pend) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL csr_read_unexpected: got 0x%08h, expected none",
                         bus.s_readdata);
            end else begin
                check(rn.pop_front(), bus.s_readdata, rq.pop_front());
            end
        end
        rd_pend = bus.s_read;
        if (bus.s_write && bus.s_address == REG_CTRL) begin
            last_ctrl = ncyc;
        end
        if (bus.m_write) begin
            hold_cnt++;
            if (bus.m_waitrequest) begin
                if (wq.size() != 0) begin
                    check("stall_data", bus.m_writedata, wq[0].data);
                end
            end else begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got 0x%08h, expected none",
                             bus.m_writedata);
                end else begin
                    e = wq.pop_front();
                    check("m_writedata", bus.m_writedata, e.data);
                    if (e.gap >= 0) begin
                        check("step_gap",
                              32'(ncyc - (e.from_ctrl ? last_ctrl : last_acc)),
                              32'(e.gap));
                    end
                    if (e.hold >= 0) begin
                        check("write_hold", 32'(hold_cnt), 32'(e.hold));
                    end
                end
                n_acc++;
                last_acc = ncyc;
                hold_cnt = 0;
            end
        end else begin
            hold_cnt = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic csr_write(input logic [4:0] a, input logic [31:0] d);
        bus.s_address   = a;
        bus.s_writedata = d;
        bus.s_write     = 1'b1;
        @(posedge clk_clk);
        #1;
        bus.s_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [4:0] a, input logic [31:0] exp,
                            input string name);
        bus.s_address = a;
        bus.s_read    = 1'b1;
        rq.push_back(exp);
        rn.push_back(name);
        @(posedge clk_clk);
        #1;
        bus.s_read    = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] d, input int gap,
                             input bit from_ctrl, input int hold);
        exp_t x;
        x.data      = d;
        x.gap       = gap;
        x.from_ctrl = from_ctrl;
        x.hold      = hold;
        wq.push_back(x);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int k;
        k = 0;
        do begin
            @(posedge clk_clk);
            k++;
        end while (n_acc < target && k < budget);
        #1;
        if (n_acc < target) begin
            checks++;
            errors++;
            $display("FAIL wait_acc_timeout: got %0d writes, expected %0d",
                     n_acc, target);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        rst_reset_n       = 1'b0;
        bus.s_address     = '0;
        bus.s_write       = 1'b0;
        bus.s_writedata   = '0;
        bus.s_read        = 1'b0;
        bus.m_waitrequest = 1'b0;
        idle(3);
        rst_reset_n = 1'b1;
        idle(1);

        // Reset state
        check("rst_m_write", 32'(bus.m_write), 32'h0);
        check("rst_m_writedata", bus.m_writedata, 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        csr_read(REG_CTRL, 32'h0, "rst_ctrl");
        csr_read(REG_STATUS, 32'h0, "rst_status");
        csr_read(REG_LENGTH, 32'h0, "rst_length");
        csr_read(REG_DWELL, 32'h0, "rst_dwell");

        // 1: three steps, 6-cycle spacing, DONE and irq
        csr_write(5'h10, 32'h1);
        csr_write(5'h11, 32'h2);
        csr_write(5'h12, 32'h4);
        csr_write(REG_LENGTH, 32'd3);
        csr_write(REG_DWELL, 32'd4);
        expect_wr(32'h1, 2, 1'b1, 1);
        expect_wr(32'h2, 6, 1'b0, 1);
        expect_wr(32'h4, 6, 1'b0, 1);
        csr_write(REG_CTRL, 32'h5);
        idle(30);
        check("t1_irq", 32'(bus.irq), 32'h1);
        csr_read(REG_STATUS, 32'h120, "t1_status");
        csr_read(REG_CTRL, 32'h4, "t1_ctrl");
        csr_write(REG_STATUS, 32'h100);
        check("t1_irq_clr", 32'(bus.irq), 32'h0);
        csr_read(REG_STATUS, 32'h020, "t1_status_clr");

        // 2: loop, then stop during DWELL
        expect_wr(32'h1, 2, 1'b1, 1);
        expect_wr(32'h2, 6, 1'b0, 1);
        expect_wr(32'h4, 6, 1'b0, 1);
        expect_wr(32'h1, 6, 1'b0, 1);
        expect_wr(32'h2, 6, 1'b0, 1);
        tgt = n_acc + 5;
        csr_write(REG_CTRL, 32'h3);
        wait_acc(tgt, 100);
        csr_write(REG_CTRL, 32'h0);
        csr_read(REG_STATUS, 32'h010, "t2_stop");
        idle(20);

        // 3: five stall cycles on step 2
        expect_wr(32'h1, 2, 1'b1, 1);
        expect_wr(32'h2, 11, 1'b0, 6);
        expect_wr(32'h4, 6, 1'b0, 1);
        csr_write(REG_CTRL, 32'h1);
        idle(6);
        bus.m_waitrequest = 1'b1;
        idle(6);
        bus.m_waitrequest = 1'b0;
        idle(20);
        csr_read(REG_STATUS, 32'h120, "t3_status");
        csr_write(REG_STATUS, 32'h100);

        // 4: empty table ignored, LENGTH clamp, zero dwell
        csr_write(REG_LENGTH, 32'd0);
        csr_write(REG_CTRL, 32'h1);
        csr_read(REG_CTRL, 32'h0, "t4_run_ignored");
        csr_read(REG_STATUS, 32'h020, "t4_status");
        csr_write(REG_LENGTH, 32'd100);
        csr_read(REG_LENGTH, 32'd16, "t4_len_clamp");
        csr_write(REG_LENGTH, 32'd16);
        csr_read(REG_LENGTH, 32'd16, "t4_len_max");
        csr_write(5'h10, 32'hA);
        csr_write(5'h11, 32'h5);
        csr_write(REG_LENGTH, 32'd2);
        csr_write(REG_DWELL, 32'd0);
        expect_wr(32'hA, 2, 1'b1, 1);
        expect_wr(32'h5, 3, 1'b0, 1);
        csr_write(REG_CTRL, 32'h1);
        idle(15);
        csr_read(REG_DWELL, 32'h0, "t4_dwell");
        csr_read(REG_STATUS, 32'h110, "t4_status_done");
        csr_write(REG_STATUS, 32'h100);

        // 5: full-width masks and readback truncation
        csr_write(5'h10, 32'h03FF_FFFF);
        csr_write(5'h11, 32'hFFFF_FFFF);
        csr_read(5'h11, 32'h03FF_FFFF, "t5_tbl1");
        csr_read(5'h10, 32'h03FF_FFFF, "t5_tbl0");
        csr_read(5'h05, 32'h0, "t5_unmapped5");
        csr_read(5'h0F, 32'h0, "t5_unmappedF");
        csr_write(REG_DWELL, 32'd1);
        expect_wr(32'h03FF_FFFF, 2, 1'b1, 1);
        expect_wr(32'h03FF_FFFF, 3, 1'b0, 1);
        csr_write(REG_CTRL, 32'h1);
        idle(15);
        csr_write(REG_STATUS, 32'h100);

        // 6: reset during a stalled WRITE
        csr_write(REG_LENGTH, 32'd1);
        bus.m_waitrequest = 1'b1;
        csr_write(REG_CTRL, 32'h1);
        idle(1);
        check("t6_m_write_on", 32'(bus.m_write), 32'h1);
        #2;
        rst_reset_n = 1'b0;
        #1;
        check("t6_m_write_drop", 32'(bus.m_write), 32'h0);
        idle(2);
        bus.m_waitrequest = 1'b0;
        rst_reset_n = 1'b1;
        idle(1);
        check("t6_m_writedata", bus.m_writedata, 32'h0);
        csr_read(REG_CTRL, 32'h0, "t6_ctrl");
        csr_read(REG_STATUS, 32'h0, "t6_status");
        csr_read(REG_LENGTH, 32'h0, "t6_length");
        csr_read(REG_DWELL, 32'h0, "t6_dwell");
        idle(3);

        check("writes_left", 32'(wq.size()), 32'h0);
        check("reads_left", 32'(rq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
